if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Decoupling stage between the PC/instruction-memory fetch and the ID stage.
//  Each cycle it accepts one {pc, instr} pair from fetch and buffers it in a small FIFO.
//  It presents the oldest entry to decode. ID holds the head under hazard-detection stall.
//  On a taken branch in ID, the queue discards everything it holds.
//  A 1-deep queue is a conventional IF/ID register; deeper queues absorb stall bubbles.
// PARAMETERS
//  DEPTH   4        entries; power of two, >=2
//  AW      $clog2(DEPTH) pointer width (derived, localparam)
//  NOP     32'h0    instruction word driven to ID when the queue is empty or after a flush
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_n_i        in   1   asynchronous active-low reset
//  start_i        in   1   global run enable; when 0 the queue neither enqueues nor dequeues
//  fetch_valid_i  in   1   fetch presents a valid {pc_i, instr_i}
//  pc_i           in   32  PC of the fetched instruction
//  instr_i        in   32  fetched instruction word
//  fetch_ready_o  out  1   queue can accept an entry this cycle (PC advances only on valid&ready)
//  stall_i        in   1   hazard detection: hold the head, do not dequeue
//  flush_i        in   1   branch taken in ID: discard all entries
//  id_valid_o     out  1   head entry valid
//  id_pc_o        out  32  head PC (32'h0 when empty)
//  id_instr_o     out  32  head instruction (NOP when empty)
// BEHAVIOUR
//  - Reset (rst_n_i low, asynchronous): rd_ptr=wr_ptr=0, count=0; fetch_ready_o=0 (start_i low),
//    id_valid_o=0, id_pc_o=0, id_instr_o=NOP. Storage contents are not reset. Reset mid-stream
//    drops every entry immediately.
//  - fetch_ready_o = start_i & (count < DEPTH). Combinational from registered count only.
//    It does not depend on a same-cycle dequeue.
//  - enq = start_i & fetch_valid_i & fetch_ready_o & ~flush_i.
//  - deq = start_i & id_valid_o & ~stall_i & ~flush_i.
//  - Outputs are driven from registered storage at rd_ptr: id_valid_o = (count != 0).
//    Latency: an entry enqueued at edge N is visible at ID after edge N (1 cycle).
//  - enq&deq same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
//  - flush_i (while start_i=1): at the next edge count=0 and rd_ptr=wr_ptr. Same-cycle fetch is
//    discarded. Flush has priority over stall_i and enq. id_valid_o=0 on the following cycle.
//  - stall_i with empty queue: no effect. stall_i with full queue: fetch_ready_o=0; fetch must hold.
//  - start_i=0: state frozen (no enq/deq/flush); outputs keep reflecting the current head.
//  - count is AW+1 bits; never exceeds DEPTH; never underflows (deq requires id_valid_o).
// CONFIGURATION
//  FETCHQ_STATS_EN defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
//   stall_cnt_o counts cycles with start_i & stall_i & id_valid_o.
//   flush_cnt_o counts cycles with start_i & flush_i.
//   Both are saturating at 32'hFFFF_FFFF and reset to 0.
//  Not defined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package fetchq_pkg: FETCHQ_DEPTH default, FETCHQ_NOP constant, typedef fetch_entry_t {pc[31:0], instr[31:0]}.
//  Sub-module fetchq_mem: DEPTH x 64-bit register array, one synchronous write port,
//   one combinational read port, no reset.
//  Top level: pointers, count, enq/deq/flush logic, and the optional stats counters.
// TESTING
//  1 reset then start_i=1, enqueue pc 0,4,8 (instr A,B,C), stall_i=0 -> ID sees 0/A,4/B,8/C
//    on consecutive cycles, each 1 cycle after enqueue.
//  2 stall_i=1 for 6 cycles with fetch streaming, DEPTH=4 -> fetch_ready_o drops after 4 entries,
//    head stays pc 0; release -> pcs drain in order with no loss or duplicate.
//  3 queue holding 3 entries, flush_i=1 with fetch_valid_i=1 (pc 0x40) -> next cycle id_valid_o=0,
//    id_instr_o=NOP; the 0x40 entry is absent; the next enqueue (0x80) appears as the head.
//  4 simultaneous enq/deq with count=DEPTH-1 for 20 cycles -> count constant; pointers wrap;
//    order preserved across the wrap.
//  5 assert rst_n_i mid-stream (async, between edges) -> id_valid_o=0 and fetch_ready_o=0 immediately;
//    after release + start_i, the first enqueue appears in order.
//  6 (FETCHQ_STATS_EN) 5 stall cycles with a valid head plus 2 flushes -> stall_cnt_o=5, flush_cnt_o=2.

Source files
------------

// File: rtl/fetchq_pkg.sv
// Shared types and constants for the IF/ID fetch queue.
// Default depth, the bubble instruction and the {pc, instr} entry bundle.
package fetchq_pkg;

  localparam int          FETCHQ_DEPTH = 4;
  localparam logic [31:0] FETCHQ_NOP   = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetchq_mem.sv
// Fetch queue storage: DEPTH x 64-bit register array, no reset.
// Ports: clk_i, we_i/waddr_i/wdata_i (sync write), raddr_i/rdata_o (comb read).
module fetchq_mem
  import fetchq_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_entry_t  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_entry_t  rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_fetch_queue.sv
// IF->ID decoupling FIFO: buffers {pc, instr}, presents oldest to ID.
// Ports: clk_i, rst_n_i, start_i, fetch_valid_i, pc_i, instr_i,
//   fetch_ready_o, stall_i, flush_i, id_valid_o, id_pc_o, id_instr_o.
// Optional (FETCHQ_STATS_EN): stall_cnt_o, flush_cnt_o.
module if_fetch_queue
  import fetchq_pkg::*;
#(
  parameter int          DEPTH = FETCHQ_DEPTH,
  parameter logic [31:0] NOP   = FETCHQ_NOP
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        fetch_ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
`ifdef FETCHQ_STATS_EN
  output logic [31:0] id_instr_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`else
  output logic [31:0] id_instr_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;

  logic         enq;
  logic         deq;
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;

  assign fetch_ready_o = start_i & (count_q < FULL);
  assign id_valid_o    = (count_q != '0);

  assign enq = start_i & fetch_valid_i
             & fetch_ready_o & ~flush_i;
  assign deq = start_i & id_valid_o
             & ~stall_i & ~flush_i;

  assign wr_entry.pc    = pc_i;
  assign wr_entry.instr = instr_i;

  fetchq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (enq),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Storage is never cleared, so mask stale words when empty.
  assign id_pc_o    = id_valid_o ? rd_entry.pc    : 32'h0;
  assign id_instr_o = id_valid_o ? rd_entry.instr : NOP;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (start_i) begin
      if (flush_i) begin
        // Empty by catching the reader up to the writer.
        rd_ptr_q <= wr_ptr_q;
        count_q  <= '0;
      end else begin
        if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
        unique case ({enq, deq})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

`ifdef FETCHQ_STATS_EN
  logic stall_hit;
  logic flush_hit;

  assign stall_hit = start_i & stall_i & id_valid_o;
  assign flush_hit = start_i & flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_hit && stall_cnt_o != 32'hFFFF_FFFF)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_hit && flush_cnt_o != 32'hFFFF_FFFF)
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue (DEPTH=4).
// Vector table plus directed wrap, reset and stats sequences.
module tb_if_fetch_queue;
  import fetchq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        fetch_valid_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        fetch_ready_o;
  logic        stall_i;
  logic        flush_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
`ifdef FETCHQ_STATS_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  if_fetch_queue dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start_i       (start_i),
    .fetch_valid_i (fetch_valid_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .fetch_ready_o (fetch_ready_o),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
`ifdef FETCHQ_STATS_EN
    .id_instr_o    (id_instr_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`else
    .id_instr_o    (id_instr_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start;
    logic        fv;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        ready;
    logic        valid;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] ins(input logic [31:0] p);
    return {16'hC0DE, p[15:0]};
  endfunction

  function automatic void add(
    input logic s, input logic fv, input logic [31:0] p,
    input logic st, input logic fl,
    input logic rdy, input logic vld, input logic [31:0] ep);
    vec_t v;
    v.start = s;   v.fv = fv;     v.pc = p;
    v.stall = st;  v.flush = fl;
    v.ready = rdy; v.valid = vld; v.epc = ep;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic fv,
                       input logic [31:0] p,
                       input logic st, input logic fl);
    start_i       = s;
    fetch_valid_i = fv;
    pc_i          = p;
    instr_i       = ins(p);
    stall_i       = st;
    flush_i       = fl;
  endtask

  task automatic chk_head(input string nm,
                          input logic vld,
                          input logic [31:0] ep);
    chk({nm, "_valid"}, 32'(id_valid_o), 32'(vld));
    chk({nm, "_pc"}, id_pc_o, vld ? ep : 32'h0);
    chk({nm, "_instr"}, id_instr_o, vld ? ins(ep) : FETCHQ_NOP);
  endtask

  logic [31:0] q[$];
  logic [31:0] nxt;

  initial begin
    rst_n_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // reset state / basic stream: 0,4,8
    add(0,0,32'h00,0,0, 0,0,32'h00);
    add(1,1,32'h00,0,0, 1,0,32'h00);
    add(1,1,32'h04,0,0, 1,1,32'h00);
    add(1,1,32'h08,0,0, 1,1,32'h04);
    add(1,0,32'h00,0,0, 1,1,32'h08);
    add(1,0,32'h00,1,0, 1,0,32'h00);
    // stall with fetch streaming, fill to DEPTH
    add(1,1,32'h00,1,0, 1,0,32'h00);
    add(1,1,32'h04,1,0, 1,1,32'h00);
    add(1,1,32'h08,1,0, 1,1,32'h00);
    add(1,1,32'h0C,1,0, 1,1,32'h00);
    add(1,1,32'h10,1,0, 0,1,32'h00);
    add(1,1,32'h10,1,0, 0,1,32'h00);
    add(1,1,32'h10,0,0, 0,1,32'h00);
    add(1,1,32'h10,0,0, 1,1,32'h04);
    add(1,0,32'h00,0,0, 1,1,32'h08);
    add(1,0,32'h00,0,0, 1,1,32'h0C);
    add(1,0,32'h00,0,0, 1,1,32'h10);
    add(1,0,32'h00,0,0, 1,0,32'h00);
    // flush with 3 held, same-cycle fetch dropped
    add(1,1,32'h20,1,0, 1,0,32'h00);
    add(1,1,32'h24,1,0, 1,1,32'h20);
    add(1,1,32'h28,1,0, 1,1,32'h20);
    add(1,1,32'h40,1,1, 1,1,32'h20);
    add(1,1,32'h80,0,0, 1,0,32'h00);
    add(1,0,32'h00,0,0, 1,1,32'h80);
    add(1,0,32'h00,0,0, 1,0,32'h00);
    // start_i low freezes state
    add(1,1,32'h90,1,0, 1,0,32'h00);
    add(0,1,32'h94,0,1, 0,1,32'h90);
    add(0,0,32'h00,0,0, 0,1,32'h90);
    add(1,0,32'h00,0,0, 1,1,32'h90);
    add(1,0,32'h00,0,0, 1,0,32'h00);

    repeat (2) @(negedge clk_i);
    chk("reset_valid", 32'(id_valid_o), 32'h0);
    chk("reset_ready", 32'(fetch_ready_o), 32'h0);
    rst_n_i = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk_i);
      drive(tbl[i].start, tbl[i].fv, tbl[i].pc,
            tbl[i].stall, tbl[i].flush);
      #1;
      chk($sformatf("v%0d_ready", i),
          32'(fetch_ready_o), 32'(tbl[i].ready));
      chk_head($sformatf("v%0d", i),
               tbl[i].valid, tbl[i].epc);
    end

    // enq+deq at count=DEPTH-1 across pointer wrap
    nxt = 32'h200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b1, nxt, 1'b1, 1'b0);
      q.push_back(nxt);
      nxt += 32'd4;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b1, nxt, 1'b0, 1'b0);
      #1;
      chk("wrap_ready", 32'(fetch_ready_o), 32'h1);
      chk_head("wrap", 1'b1, q[0]);
      void'(q.pop_front());
      q.push_back(nxt);
      nxt += 32'd4;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk_head("drain", 1'b1, q[0]);
      void'(q.pop_front());
    end
    @(negedge clk_i);
    #1;
    chk_head("drain_empty", 1'b0, 32'h0);

    // async reset mid-stream
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b1, 32'h300 + 32'(4*k), 1'b1, 1'b0);
    end
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("arst_ready", 32'(fetch_ready_o), 32'h0);
    chk_head("arst", 1'b0, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    drive(1'b1, 1'b1, 32'h400, 1'b0, 1'b0);
    #1;
    chk("post_rst_ready", 32'(fetch_ready_o), 32'h1);
    chk_head("post_rst0", 1'b0, 32'h0);
    @(negedge clk_i);
    drive(1'b1, 1'b1, 32'h404, 1'b0, 1'b0);
    #1;
    chk_head("post_rst1", 1'b1, 32'h400);
    @(negedge clk_i);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk_head("post_rst2", 1'b1, 32'h404);
    @(negedge clk_i);
    #1;
    chk_head("post_rst3", 1'b0, 32'h0);

`ifdef FETCHQ_STATS_EN
    @(negedge clk_i);
    rst_n_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("stats_rst_stall", stall_cnt_o, 32'h0);
    chk("stats_rst_flush", flush_cnt_o, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    drive(1'b1, 1'b1, 32'h500, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    @(negedge clk_i);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("stats_stall", stall_cnt_o, 32'd5);
    chk("stats_flush", flush_cnt_o, 32'd2);
    chk_head("stats_after", 1'b0, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
